// File: rtl/ai_fifo_write_arbiter.sv
// Shares one AI FIFO write port among N_REQ producers using bounded round-robin bursts.
// Define AI_ARB_FIXED_PRIO_EN for lowest-index priority with preemption at the next accepted word.
module ai_fifo_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0]                      req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]           req_data,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic                                  fifo_full,
  output logic                                  fifo_w_en,
  output logic [$clog2(N_REQ)+DATA_WIDTH-1:0]   fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]              grant_id,
  output logic                                  busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN - 1);
  localparam logic [BC_W-1:0] BURST_TOP = BC_W'(BURST_LEN);
  localparam logic [IC_W-1:0] IDLE_MAX  = IC_W'(IDLE_TIMEOUT - 1);
  localparam logic [IC_W-1:0] IDLE_TOP  = IC_W'(IDLE_TIMEOUT);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [BC_W-1:0]       burst_cnt_q;
  logic [IC_W-1:0]       idle_cnt_q;

  logic [ID_W-1:0]       winner;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  accept;
  logic                  preempt;
  logic                  burst_done;

  // Mux out the current owner's request signals
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AI_ARB_FIXED_PRIO_EN
  // Lowest valid index wins; any lower valid index forces release on the next accepted word
  always_comb begin
    winner  = '0;
    preempt = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = ID_W'(i);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) < grant_q && req_valid[i]) preempt = 1'b1;
    end
  end
`else
  logic [ID_W-1:0] rr_idx;

  // Scan from farthest to nearest so the first valid index after rr_ptr is the final winner
  always_comb begin
    winner  = '0;
    rr_idx  = '0;
    preempt = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[rr_idx]) winner = rr_idx;
    end
  end
`endif

  always_comb begin
    busy         = (state_q == BURST) && !rst;
    accept       = busy && owner_valid && !fifo_full;
    fifo_w_en    = accept;
    fifo_data_in = accept ? {grant_q, owner_data} : '0;
    grant_id     = rst ? '0 : grant_q;
    req_ready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && grant_q == ID_W'(i)) req_ready[i] = 1'b1;
    end
    burst_done = (accept && (owner_last || burst_cnt_q == BURST_MAX || preempt)) ||
                 (!owner_valid && idle_cnt_q == IDLE_MAX);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = BURST;
      BURST:   if (burst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stalls on fifo_full leave idle_cnt untouched so backpressure never revokes a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q     <= winner;
`ifndef AI_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= winner;
`endif
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            if (burst_cnt_q != BURST_TOP) burst_cnt_q <= burst_cnt_q + BC_W'(1);
            idle_cnt_q <= '0;
          end else if (!owner_valid && idle_cnt_q != IDLE_TOP) begin
            idle_cnt_q <= idle_cnt_q + IC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
